multiport_register_file: RTL and testbench

Parametrised successor to the tensor core's 8-bit, 256-entry, two-read-port register file. It adds configurable data width, depth and read-port count, and registers every read with one cycle of latency. A write in the same cycle as a read of that address bypasses through to the read result. A hardware clear sequencer zeroes the whole array after reset or on request. It sits between the instruction decoder / load path and the MAC array as the operand store.

---
 rtl/multiport_register_file.sv | 115 +++++++++++
 tb/tb_multiport_register_file.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Operand register file: N registered read ports, one write port with write-first
// bypass, and a clear sequencer that zeroes the array after reset or on request.
module multiport_register_file #(
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned NUMBER_OF_REGISTERS    = 256,
  parameter int unsigned NUMBER_OF_READ_PORTS   = 2,
  localparam int unsigned ADDRESS_WIDTH         = $clog2(NUMBER_OF_REGISTERS)
) (
  input  logic                                         clock_in,
  input  logic                                         reset_in,
  input  logic                                         clear_request_in,
  input  logic                                         write_enable_in,
  input  logic [ADDRESS_WIDTH-1:0]                     write_register_address_in,
  input  logic [DATA_WIDTH-1:0]                        write_data_in,
  input  logic [NUMBER_OF_READ_PORTS*ADDRESS_WIDTH-1:0] read_register_addresses_in,
  output logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0]    read_data_out,
  output logic                                         clear_busy_out,
  output logic                                         write_dropped_out
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(NUMBER_OF_REGISTERS - 1);

  logic [0:0]                                      r_state;
  logic [ADDRESS_WIDTH-1:0]                        r_clear_address;
  logic                                            r_clear_busy;
  logic                                            r_write_dropped;
  logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0]      r_read_data;
  logic [DATA_WIDTH-1:0]                           r_registers [NUMBER_OF_REGISTERS];

  logic [0:0]                                      w_state_next;
  logic [ADDRESS_WIDTH-1:0]                        w_clear_address_next;
  logic                                            w_clear_busy_next;
  logic                                            w_write_dropped_next;
  logic                                            w_array_write;
  logic [ADDRESS_WIDTH-1:0]                        w_array_address;
  logic [DATA_WIDTH-1:0]                           w_array_data;
  logic [NUMBER_OF_READ_PORTS*DATA_WIDTH-1:0]      w_read_data_next;

  // Next-state logic; the clear sequencer owns the array write port while in CLEAR.
  always_comb begin
    w_state_next         = r_state;
    w_clear_address_next = r_clear_address;
    w_clear_busy_next    = r_clear_busy;
    w_write_dropped_next = 1'b0;
    w_array_write        = 1'b0;
    w_array_address      = write_register_address_in;
    w_array_data         = write_data_in;
    if (r_state == ST_CLEAR) begin
      w_array_write        = 1'b1;
      w_array_address      = r_clear_address;
      w_array_data         = '0;
      w_clear_address_next = r_clear_address + ADDRESS_WIDTH'(1);
      w_write_dropped_next = write_enable_in;
      if (r_clear_address == LAST_ADDRESS) begin
        w_state_next      = ST_READY;
        w_clear_busy_next = 1'b0;
      end
    end else begin
      w_array_write = write_enable_in;
      if (clear_request_in) begin
        w_state_next         = ST_CLEAR;
        w_clear_address_next = '0;
        w_clear_busy_next    = 1'b1;
      end
    end
    if (reset_in) begin
      w_array_write = 1'b0;
    end
  end

  // Reads are masked to zero during CLEAR so uninitialised contents never escape.
  always_comb begin
    w_read_data_next = '0;
    for (int p = 0; p < int'(NUMBER_OF_READ_PORTS); p++) begin
      if (r_state == ST_READY) begin
        if (write_enable_in &&
            (read_register_addresses_in[p*ADDRESS_WIDTH +: ADDRESS_WIDTH] == write_register_address_in)) begin
          w_read_data_next[p*DATA_WIDTH +: DATA_WIDTH] = write_data_in;
        end else begin
          w_read_data_next[p*DATA_WIDTH +: DATA_WIDTH] =
            r_registers[read_register_addresses_in[p*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
        end
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state         <= ST_CLEAR;
      r_clear_address <= '0;
      r_clear_busy    <= 1'b1;
      r_write_dropped <= 1'b0;
      r_read_data     <= '0;
    end else begin
      r_state         <= w_state_next;
      r_clear_address <= w_clear_address_next;
      r_clear_busy    <= w_clear_busy_next;
      r_write_dropped <= w_write_dropped_next;
      r_read_data     <= w_read_data_next;
    end
  end

  always_ff @(posedge clock_in) begin
    if (w_array_write) begin
      r_registers[w_array_address] <= w_array_data;
    end
  end

  assign read_data_out     = r_read_data;
  assign clear_busy_out    = r_clear_busy;
  assign write_dropped_out = r_write_dropped;

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench: default 8x256x2 instance plus a 16x4x3 instance for the parameter sweep.
module tb_multiport_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr, we;
  logic [7:0]  waddr, wdata;
  logic [15:0] raddr;
  logic [15:0] rdata;
  logic        busy, dropped;

  logic        s_rst, s_clr, s_we;
  logic [1:0]  s_waddr;
  logic [15:0] s_wdata;
  logic [5:0]  s_raddr;
  logic [47:0] s_rdata;
  logic        s_busy, s_dropped;

  int errors = 0;
  int checks = 0;

  multiport_register_file dut (
    .clock_in                   (clk),
    .reset_in                   (rst),
    .clear_request_in           (clr),
    .write_enable_in            (we),
    .write_register_address_in  (waddr),
    .write_data_in              (wdata),
    .read_register_addresses_in (raddr),
    .read_data_out              (rdata),
    .clear_busy_out             (busy),
    .write_dropped_out          (dropped)
  );

  multiport_register_file #(
    .DATA_WIDTH           (16),
    .NUMBER_OF_REGISTERS  (4),
    .NUMBER_OF_READ_PORTS (3)
  ) dut_small (
    .clock_in                   (clk),
    .reset_in                   (s_rst),
    .clear_request_in           (s_clr),
    .write_enable_in            (s_we),
    .write_register_address_in  (s_waddr),
    .write_data_in              (s_wdata),
    .read_register_addresses_in (s_raddr),
    .read_data_out              (s_rdata),
    .clear_busy_out             (s_busy),
    .write_dropped_out          (s_dropped)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive busy-high samples (current one included), bounded.
  task automatic count_busy(output int cnt, output int nonzero_reads);
    cnt = 0;
    nonzero_reads = 0;
    while (busy === 1'b1 && cnt < 400) begin
      if (rdata !== 16'h0000) nonzero_reads++;
      cnt++;
      tick();
    end
  endtask

  task automatic count_small_busy(output int cnt);
    cnt = 0;
    while (s_busy === 1'b1 && cnt < 50) begin
      cnt++;
      tick();
    end
  endtask

  int cnt, nz, drops_bad, reads_bad;

  initial begin
    rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = 16'h3412;
    s_rst = 1'b1; s_clr = 1'b0; s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_raddr = '0;

    // 1: reset state and power-on clear timing
    repeat (3) tick();
    check("reset_busy", 64'(busy), 64'd1);
    check("reset_rdata", 64'(rdata), 64'd0);
    check("reset_dropped", 64'(dropped), 64'd0);
    rst = 1'b0;
    count_busy(cnt, nz);
    check("t1_busy_cycles", 64'(cnt), 64'd256);
    check("t1_reads_zero", 64'(nz), 64'd0);

    // 2: write then read on both ports
    we = 1'b1; waddr = 8'h10; wdata = 8'hA5; raddr = 16'h0000;
    tick();
    we = 1'b0; raddr = {8'h10, 8'h10};
    tick();
    check("t2_read_both", 64'(rdata), 64'hA5A5);
    raddr = {8'h11, 8'h11};
    tick();
    check("t2_read_unwritten", 64'(rdata), 64'h0000);
    check("t2_no_drop", 64'(dropped), 64'd0);

    // 3: write-first bypass
    we = 1'b1; waddr = 8'h20; wdata = 8'h3C; raddr = {8'h20, 8'h21};
    tick();
    check("t3_bypass", 64'(rdata), 64'h3C00);
    we = 1'b0; raddr = {8'h21, 8'h20};
    tick();
    check("t3_stored", 64'(rdata), 64'h003C);

    // 4: runtime clear, write in the request cycle, dropped writes during clear
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; waddr = 8'(i); wdata = 8'((i + 1) * 17);
      tick();
    end
    we = 1'b1; waddr = 8'h05; wdata = 8'h77; clr = 1'b1; raddr = {8'h01, 8'h00};
    tick();
    check("t4_last_ready_read", 64'(rdata), 64'h2211);
    check("t4_busy_start", 64'(busy), 64'd1);
    clr = 1'b0;
    cnt = 1; drops_bad = 0; reads_bad = 0;
    raddr = {8'h03, 8'h05};
    for (int i = 0; i < 400; i++) begin
      we = (i < 3); waddr = 8'h06; wdata = 8'h99;
      clr = (i == 20);
      tick();
      if (dropped !== 1'(i < 3)) drops_bad++;
      if (rdata !== 16'h0000) reads_bad++;
      if (busy !== 1'b1) break;
      cnt++;
    end
    we = 1'b0; clr = 1'b0;
    check("t4_busy_cycles", 64'(cnt), 64'd256);
    check("t4_dropped_pattern", 64'(drops_bad), 64'd0);
    check("t4_reads_masked", 64'(reads_bad), 64'd0);
    for (int a = 0; a < 7; a++) begin
      raddr = {8'(a), 8'(a)};
      tick();
      check($sformatf("t4_cleared_%0d", a), 64'(rdata), 64'h0000);
    end
    check("t4_drop_idle", 64'(dropped), 64'd0);

    // 5: reset in the middle of a clear restarts it
    we = 1'b1; waddr = 8'h30; wdata = 8'hAB;
    tick();
    we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (99) tick();
    check("t5_busy_mid", 64'(busy), 64'd1);
    rst = 1'b1; we = 1'b1;
    tick();
    check("t5_reset_busy", 64'(busy), 64'd1);
    check("t5_reset_dropped", 64'(dropped), 64'd0);
    rst = 1'b0; we = 1'b0;
    count_busy(cnt, nz);
    check("t5_busy_cycles", 64'(cnt), 64'd256);
    raddr = {8'h30, 8'h30};
    tick();
    check("t5_cleared", 64'(rdata), 64'h0000);

    // 6: parameter sweep instance
    s_rst = 1'b0;
    count_small_busy(cnt);
    check("t6_clear_cycles", 64'(cnt), 64'd4);
    s_we = 1'b1; s_waddr = 2'd3; s_wdata = 16'hBEEF;
    tick();
    s_we = 1'b0; s_raddr = {2'd3, 2'd3, 2'd3};
    tick();
    check("t6_port0", 64'(s_rdata[15:0]), 64'hBEEF);
    check("t6_port1", 64'(s_rdata[31:16]), 64'hBEEF);
    check("t6_port2", 64'(s_rdata[47:32]), 64'hBEEF);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    count_small_busy(cnt);
    check("t6_second_clear", 64'(cnt), 64'd4);
    s_raddr = {2'd1, 2'd2, 2'd3};
    tick();
    check("t6_cleared", 64'(s_rdata), 64'h0);
    s_we = 1'b1; s_waddr = 2'd0; s_wdata = 16'h1234; s_raddr = {2'd3, 2'd1, 2'd0};
    tick();
    check("t6_bypass", 64'(s_rdata), 64'h0000_0000_1234);
    s_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
